sm4_decryptor: RTL and testbench
================================

// Module: sm4_decryptor
// PURPOSE
//  Iterative SM4 block decryptor. It is the inverse-direction counterpart of the encryption round path.
//  - Takes a 128-bit ciphertext and returns a 128-bit plaintext.
//  - Runs 32 rounds, one round per clock.
//  - Uses the same round function T as encryption, but applies the round keys in reverse order (rk[31]..rk[0]).
//  - Contains its own 32x32 round-key store, written by the key-expansion block.
// PARAMETERS
//  group_size_p   128  block width (taken from sm4_encryptor package, not overridable)
//  word_width_p   32   word width (package)
//  byte_width_p   8    S-box lane width (package)
//  rounds_p       32   number of rounds (package)
// PORTS
//  clk_i       in   1    clock
//  reset_i     in   1    synchronous, active-high reset
//  rk_v_i      in   1    round-key write strobe
//  rk_addr_i   in   5    round-key index (0..31, in encryption order)
//  rk_data_i   in   32   round-key value
//  rk_ready_o  out  1    key store writable (state==IDLE)
//  keys_ok_o   out  1    all 32 round keys written since reset
//  in_v_i      in   1    ciphertext valid
//  in_data_i   in   128  ciphertext; X0 = [127:96] ... X3 = [31:0]
//  in_ready_o  out  1    accepts a block (IDLE && keys_ok_o)
//  out_v_o     out  1    plaintext valid (state==DONE)
//  out_data_o  out  128  plaintext
//  out_ready_i in   1    consumer accepts the plaintext
// BEHAVIOUR
//  Reset values:
//  - rk_ready_o = 1, keys_ok_o = 0, in_ready_o = 0, out_v_o = 0, out_data_o = 0.
//  - State = IDLE, round counter = 0, written-mask = 0.
//  - Key contents are don't-care after reset.
//  Key store:
//  - Write occurs when rk_v_i && rk_ready_o: mem[rk_addr_i] <= rk_data_i, and mask bit rk_addr_i is set.
//  - keys_ok_o = &mask.
//  - Rewriting an entry is legal; the new value takes effect for the next block.
//  - Writes while not IDLE are ignored and do not set mask bits.
//  FSM IDLE -> ROUND -> DONE -> IDLE:
//  - IDLE: in_v_i && in_ready_o latches X0..X3 from in_data_i, sets ctr = 0, goes to ROUND.
//  - ROUND: each cycle applies one round (below) and increments ctr; ctr == 31 goes to DONE.
//  - DONE: out_v_o = 1. out_ready_i returns to IDLE. Otherwise out_v_o and out_data_o hold stable.
//  - No new block is accepted in the same cycle an output is taken (throughput is 34 cycles per block minimum).
//  Round r (r = ctr):
//  - X_{r+4} = X_r ^ T(X_{r+1} ^ X_{r+2} ^ X_{r+3} ^ mem[31-r]).
//  - The state shifts left by one word.
//  - mem is read combinationally, indexed by ~ctr.
//  T(A):
//  - Four parallel S-box lookups on bytes of A give B.
//  - L(B) = B ^ rol(B,2) ^ rol(B,10) ^ rol(B,18) ^ rol(B,24).
//  Output:
//  - out_data_o = {X35, X34, X33, X32}, i.e. the reverse transform R is applied.
//  - It is registered when entering DONE.
//  Latency:
//  - Acceptance edge E0; round edges E1..E32.
//  - out_v_o is high in the cycle after E32, i.e. 32 cycles after acceptance.
//  Boundaries:
//  - in_v_i with keys_ok_o = 0: no acceptance, in_ready_o = 0.
//  - in_data_i changes after acceptance: no effect.
//  - reset_i in any state: the in-flight block is discarded; outputs and mask go to reset values the next cycle.
//  - out_ready_i while not in DONE: ignored.
// STRUCTURE
//  Package sm4_encryptor (shared):
//  - group_size_p, word_width_p, byte_width_p, rounds_p.
//  - Shift constants for content L (2, 10, 18, 24) and for key L' (13, 23).
//  - typedef state_e {IDLE, ROUND, DONE}.
//  Sub-module:
//  - One combinational turn_transform instance, is_key_i = 0.
//  - Its i input carries {X_{r+1}, X_{r+2}, X_{r+3}} in the upper 96 bits.
//  - Its rkey_i input carries mem[31-r]; its o output is the T result.
//  - The XOR with X_r is done in this module.
//  Key memory:
//  - Flop array (32x32), not SRAM, because an asynchronous read is required.
// TESTING
//  1. Load rk for key 0123456789abcdeffedcba9876543210 (rk0 = f12186f9, rk31 = 9124a012).
//     - Input ciphertext 681edf34d206965e86b3e94f536e4246.
//     - Expect plaintext 0123456789abcdeffedcba9876543210 exactly 32 cycles after acceptance.
//  2. Same key; write only 31 of the 32 entries, then in_v_i = 1.
//     - Expect in_ready_o = 0 and out_v_o = 0 for 100 cycles.
//     - Write the final entry; expect acceptance on the next cycle.
//  3. Hold out_ready_i = 0 for 10 cycles in DONE.
//     - Expect out_data_o to stay stable and in_ready_o = 0.
//     - A rk write attempted with rk_data_i = 0 is ignored; the next block still decrypts correctly.
//  4. Pulse reset_i at round 15.
//     - Next cycle expect out_v_o = 0, keys_ok_o = 0, in_ready_o = 0.
//     - Reload keys, re-submit the block; expect correct plaintext.
//  5. Back-to-back: submit two ciphertexts with out_ready_i tied to 1.
//     - Expect both plaintexts correct.
//     - The second acceptance occurs no earlier than 34 cycles after the first.
//  6. Round trip: random key and plaintext; encrypt with the golden model, decrypt with the DUT.
//     - Expect the original plaintext, over 1000 iterations.

Source files
------------

// File: rtl/sm4_decryptor_pkg.sv
// Shared SM4 constants, FSM state type and the S-box / rotate helpers
// used by the decryptor round datapath.
package sm4_decryptor_pkg;

  localparam int group_size_p = 128;
  localparam int word_width_p = 32;
  localparam int byte_width_p = 8;
  localparam int rounds_p     = 32;

  // Rotate amounts for the data-path L and the key-schedule L'
  localparam int l_sh0_p  = 2;
  localparam int l_sh1_p  = 10;
  localparam int l_sh2_p  = 18;
  localparam int l_sh3_p  = 24;
  localparam int lk_sh0_p = 13;
  localparam int lk_sh1_p = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] sbox_tbl_p [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [byte_width_p-1:0] sbox(input logic [byte_width_p-1:0] a);
    return sbox_tbl_p[a];
  endfunction

  function automatic logic [word_width_p-1:0] rol32(input logic [word_width_p-1:0] x,
                                                     input int n);
    return (x << n) | (x >> (word_width_p - n));
  endfunction

endpackage

// File: rtl/sm4_decryptor_turn_transform.sv
// Combinational SM4 round transform: T(A) for data rounds, T'(A) for the key schedule.
// A is the XOR of the three upper words of i with rkey_i.
module turn_transform
  import sm4_decryptor_pkg::*;
(
  input  logic [group_size_p-1:word_width_p] i,
  input  logic [word_width_p-1:0]            rkey_i,
  input  logic                               is_key_i,
  output logic [word_width_p-1:0]            o
);

  logic [word_width_p-1:0] w_a;
  logic [word_width_p-1:0] w_b;

  always_comb begin
    w_a = i[127:96] ^ i[95:64] ^ i[63:32] ^ rkey_i;
    w_b = '0;
    for (int k = 0; k < word_width_p / byte_width_p; k++) begin
      w_b[k*byte_width_p +: byte_width_p] = sbox(w_a[k*byte_width_p +: byte_width_p]);
    end
    if (is_key_i) begin
      o = w_b ^ rol32(w_b, lk_sh0_p) ^ rol32(w_b, lk_sh1_p);
    end else begin
      o = w_b ^ rol32(w_b, l_sh0_p) ^ rol32(w_b, l_sh1_p) ^ rol32(w_b, l_sh2_p)
            ^ rol32(w_b, l_sh3_p);
    end
  end

endmodule

// File: rtl/sm4_decryptor.sv
// Iterative SM4 block decryptor: one round per clock, round keys consumed
// from a local flop-based key store in reverse order (rk[31] first).
module sm4_decryptor
  import sm4_decryptor_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    rk_v_i,
  input  logic [4:0]              rk_addr_i,
  input  logic [word_width_p-1:0] rk_data_i,
  output logic                    rk_ready_o,
  output logic                    keys_ok_o,
  input  logic                    in_v_i,
  input  logic [group_size_p-1:0] in_data_i,
  output logic                    in_ready_o,
  output logic                    out_v_o,
  output logic [group_size_p-1:0] out_data_o,
  input  logic                    out_ready_i
);

  logic [word_width_p-1:0] r_mem [rounds_p];
  logic [rounds_p-1:0]     r_mask;
  state_e                  r_state;
  logic [4:0]              r_ctr;
  logic [group_size_p-1:0] r_x;
  logic                    r_out_v;
  logic [group_size_p-1:0] r_out_data;

  logic                    w_rk_we;
  logic                    w_accept;
  logic [word_width_p-1:0] w_rkey;
  logic [word_width_p-1:0] w_t;
  logic [word_width_p-1:0] w_new;

  assign rk_ready_o = (r_state == IDLE);
  assign keys_ok_o  = &r_mask;
  assign in_ready_o = rk_ready_o && keys_ok_o;
  assign out_v_o    = r_out_v;
  assign out_data_o = r_out_data;

  assign w_rk_we  = rk_v_i && rk_ready_o && !reset_i;
  assign w_accept = in_v_i && in_ready_o;
  // Keys are stored in encryption order; ~ctr walks them from 31 down to 0
  assign w_rkey   = r_mem[~r_ctr];
  assign w_new    = r_x[127:96] ^ w_t;

  turn_transform u_turn (
    .i        (r_x[95:0]),
    .rkey_i   (w_rkey),
    .is_key_i (1'b0),
    .o        (w_t)
  );

  // Round-key store: asynchronous read, so it stays a flop array
  always_ff @(posedge clk_i) begin
    if (w_rk_we) begin
      r_mem[rk_addr_i] <= rk_data_i;
    end
  end

  // Written-entry mask
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mask <= '0;
    end else if (w_rk_we) begin
      r_mask[rk_addr_i] <= 1'b1;
    end
  end

  // Control FSM and round datapath
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_ctr      <= 5'd0;
      r_x        <= '0;
      r_out_v    <= 1'b0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x     <= in_data_i;
            r_ctr   <= 5'd0;
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_x   <= {r_x[95:0], w_new};
          r_ctr <= r_ctr + 5'd1;
          if (r_ctr == 5'd31) begin
            r_state    <= DONE;
            r_out_v    <= 1'b1;
            // Reverse transform R: {X35, X34, X33, X32}
            r_out_data <= {w_new, r_x[31:0], r_x[63:32], r_x[95:64]};
          end
        end
        DONE: begin
          if (out_ready_i) begin
            r_out_v <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_out_v <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_decryptor.sv
// Self-checking bench for sm4_decryptor: golden SM4 encrypt model, vector table and scoreboard.
module tb_sm4_decryptor;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         rk_v_i;
  logic [4:0]   rk_addr_i;
  logic [31:0]  rk_data_i;
  logic         rk_ready_o;
  logic         keys_ok_o;
  logic         in_v_i;
  logic [127:0] in_data_i;
  logic         in_ready_o;
  logic         out_v_o;
  logic [127:0] out_data_o;
  logic         out_ready_i;

  always #5 clk_i = ~clk_i;

  sm4_decryptor dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .rk_v_i(rk_v_i), .rk_addr_i(rk_addr_i), .rk_data_i(rk_data_i),
    .rk_ready_o(rk_ready_o), .keys_ok_o(keys_ok_o),
    .in_v_i(in_v_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .out_v_o(out_v_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = -1000;
  logic prev_v = 1'b0;
  logic [127:0] exp_q [$];
  logic [127:0] cur_exp = '0;
  logic [31:0]  mrk [32];
  logic [127:0] loaded_key = '0;

  logic [7:0] sb [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // ---------------- golden model (encryption direction) ----------------
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {sb[a[31:24]], sb[a[23:16]], sb[a[15:8]], sb[a[7:0]]};
  endfunction

  function automatic logic [31:0] t_data(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  function automatic logic [31:0] ck(input int i);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'(((4 * i) + j) * 7);
    return w;
  endfunction

  function automatic void expand(input logic [127:0] mk);
    logic [31:0] k [36];
    k[0] = mk[127:96] ^ 32'ha3b1bac6;
    k[1] = mk[95:64]  ^ 32'h56aa3350;
    k[2] = mk[63:32]  ^ 32'h677d9197;
    k[3] = mk[31:0]   ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck(i));
      mrk[i] = k[i+4];
    end
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [31:0] x [36];
    x[0] = pt[127:96]; x[1] = pt[95:64]; x[2] = pt[63:32]; x[3] = pt[31:0];
    for (int i = 0; i < 32; i++) x[i+4] = x[i] ^ t_data(x[i+1] ^ x[i+2] ^ x[i+3] ^ mrk[i]);
    return {x[35], x[34], x[33], x[32]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_key(input logic [4:0] addr, input logic [31:0] data);
    rk_v_i = 1'b1; rk_addr_i = addr; rk_data_i = data;
    step();
    rk_v_i = 1'b0;
  endtask

  task automatic load_keys(input logic [127:0] key, input bit skip_last);
    expand(key);
    loaded_key = key;
    for (int a = 0; a < 32; a++) begin
      if (!(skip_last && a == 31)) write_key(5'(a), mrk[a]);
    end
  endtask

  task automatic submit(input logic [127:0] ct, input logic [127:0] pt);
    int n;
    n = 0;
    in_data_i = ct; cur_exp = pt; in_v_i = 1'b1;
    while (!in_ready_o && n < 200) begin step(); n++; end
    chk("submit_timeout", 128'(n < 200), 128'(1));
    step();
    in_v_i = 1'b0;
    in_data_i = rnd128();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_v_o) && n < 300) begin step(); n++; end
    chk("drain_timeout", 128'(n < 300), 128'(1));
  endtask

  // Scoreboard: push on acceptance, pop on output handshake
  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
      if (reset_i) begin
        exp_q.delete();
        prev_v = 1'b0;
      end else begin
        if (in_v_i && in_ready_o) begin
          chk("accept_gap", 128'((cyc - acc_cyc) >= 34), 128'(1));
          acc_cyc = cyc;
          exp_q.push_back(cur_exp);
        end
        // valid rose at the previous edge, which must be acceptance + 32
        if (out_v_o && !prev_v) chk("latency", 128'(cyc - 1 - acc_cyc), 128'(32));
        if (out_v_o && out_ready_i) begin
          if (exp_q.size() == 0) chk("unexpected_output", 128'(1), 128'(0));
          else chk("plaintext", out_data_o, exp_q.pop_front());
        end
        prev_v = out_v_o;
      end
    end
  end

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  localparam logic [127:0] K0  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT0 = 128'h681edf34d206965e86b3e94f536e4246;

  initial begin
    vec_t tbl [6];
    logic [127:0] pt_a, pt_b, pt_r, key_r;
    int n;

    tbl[0] = '{key: K0, ct: CT0, pt: K0};
    for (int v = 1; v < 6; v++) begin
      tbl[v].key = rnd128();
      tbl[v].pt  = rnd128();
      expand(tbl[v].key);
      tbl[v].ct  = encrypt(tbl[v].pt);
    end

    reset_i = 1'b1; rk_v_i = 1'b0; rk_addr_i = 5'd0; rk_data_i = 32'd0;
    in_v_i = 1'b0; in_data_i = '0; out_ready_i = 1'b1;
    repeat (3) step();
    chk("rst_rk_ready", 128'(rk_ready_o), 128'(1));
    chk("rst_keys_ok", 128'(keys_ok_o), 128'(0));
    chk("rst_in_ready", 128'(in_ready_o), 128'(0));
    chk("rst_out_v", 128'(out_v_o), 128'(0));
    chk("rst_out_data", out_data_o, 128'(0));
    reset_i = 1'b0;

    // Only 31 keys: no acceptance; final write enables it
    load_keys(K0, 1'b1);
    in_data_i = CT0; cur_exp = K0; in_v_i = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      chk("partial_in_ready", 128'(in_ready_o), 128'(0));
      chk("partial_out_v", 128'(out_v_o), 128'(0));
    end
    write_key(5'd31, mrk[31]);
    chk("keys_ok_after_last", 128'(keys_ok_o), 128'(1));
    chk("in_ready_after_last", 128'(in_ready_o), 128'(1));
    step();
    in_v_i = 1'b0;
    in_data_i = rnd128();
    drain();

    // Vector table
    for (int v = 0; v < 6; v++) begin
      if (tbl[v].key !== loaded_key) load_keys(tbl[v].key, 1'b0);
      submit(tbl[v].ct, tbl[v].pt);
      drain();
    end

    // Stall in DONE with an ignored key write
    load_keys(K0, 1'b0);
    out_ready_i = 1'b0;
    submit(CT0, K0);
    n = 0;
    while (!out_v_o && n < 100) begin step(); n++; end
    chk("done_timeout", 128'(n < 100), 128'(1));
    for (int c = 0; c < 10; c++) begin
      rk_v_i = 1'b1; rk_addr_i = 5'd31; rk_data_i = 32'd0;
      step();
      chk("stall_data", out_data_o, K0);
      chk("stall_v", 128'(out_v_o), 128'(1));
      chk("stall_in_ready", 128'(in_ready_o), 128'(0));
      chk("stall_rk_ready", 128'(rk_ready_o), 128'(0));
    end
    rk_v_i = 1'b0;
    out_ready_i = 1'b1;
    drain();
    submit(CT0, K0);
    drain();

    // Reset in the middle of the rounds
    submit(CT0, K0);
    repeat (15) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("midrst_out_v", 128'(out_v_o), 128'(0));
    chk("midrst_keys_ok", 128'(keys_ok_o), 128'(0));
    chk("midrst_in_ready", 128'(in_ready_o), 128'(0));
    chk("midrst_out_data", out_data_o, 128'(0));
    repeat (40) step();
    chk("midrst_no_output", 128'(out_v_o), 128'(0));
    load_keys(K0, 1'b0);
    submit(CT0, K0);
    drain();

    // Back-to-back blocks
    pt_a = rnd128();
    pt_b = rnd128();
    submit(encrypt(pt_a), pt_a);
    submit(encrypt(pt_b), pt_b);
    drain();

    // Round trip: random keys (new one every 10 blocks) and plaintexts
    for (int k = 0; k < 100; k++) begin
      key_r = rnd128();
      load_keys(key_r, 1'b0);
      for (int j = 0; j < 10; j++) begin
        pt_r = rnd128();
        submit(encrypt(pt_r), pt_r);
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
